gate_vec_checker: RTL

Self-checking vector sequencer for small combinational gates such as the team's nand2.
- Drives every input combination of an N_IN-input gate exhaustively.
- Waits a programmable settle time for each vector.
- Samples the gate output and compares it against a parameterised truth table.
- Reports a pass/fail summary and the first failing vector.
- Sits directly upstream of the gate under test (feeds its inputs) and downstream of it (consumes its output). This replaces hand-written delay loops in gate benches.

---
 rtl/gate_chk_pkg.sv | 18 +
 rtl/gate_chk_settle_timer.sv | 29 ++
 rtl/gate_vec_checker.sv | 122 ++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and reference truth tables for the gate vector checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } gate_chk_state_t;

  // Bit i is the expected gate output when the input vector equals i.
  localparam logic [3:0] NAND2_TT = 4'b0111;
  localparam logic [3:0] AND2_TT  = 4'b1000;
  localparam logic [3:0] OR2_TT   = 4'b1110;
  localparam logic [3:0] XOR2_TT  = 4'b0110;
  localparam logic [1:0] NOT_TT   = 2'b01;

endpackage : gate_chk_pkg

// File: rtl/gate_chk_settle_timer.sv
// Settle-time counter: cleared on load, advances on count, flags the last
// settle cycle. A zero settle time reports expiry unconditionally.
module gate_chk_settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire_c = (SETTLE == 0) || (r_cnt == CNT_W'(SETTLE - 1));

endmodule : gate_chk_settle_timer

// File: rtl/gate_vec_checker.sv
// Exhaustive input sweep and truth-table check for a small combinational gate.
// Define GATE_VEC_CHECKER_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_vec_checker #(
  parameter int unsigned                N_IN   = 2,
  parameter logic [(1 << N_IN)-1:0]     TRUTH  = gate_chk_pkg::NAND2_TT,
  parameter int unsigned                SETTLE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [N_IN-1:0]   o_dut_in,
  input  logic              i_dut_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [N_IN:0]     o_err_count,
  output logic [N_IN-1:0]   o_first_fail_vec,
  output logic              o_first_fail_valid
);

  import gate_chk_pkg::*;

  localparam int unsigned VEC_W = N_IN;
  localparam int unsigned ERR_W = N_IN + 1;

  gate_chk_state_t  r_state;
  logic [VEC_W-1:0] r_dut_in;
  logic [ERR_W-1:0] r_err_count;
  logic [VEC_W-1:0] r_first_fail_vec;
  logic             r_first_fail_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_start_ok;
  logic             w_mismatch;
  logic             w_last_vec;
  logic             w_expire;
  logic             w_timer_load;
  logic             w_timer_count;
  gate_chk_state_t  w_vec_state;

  assign w_start_ok    = i_start && ((r_state == IDLE) || (r_state == DONE));
  // Case inequality so an X or Z from the gate is reported as a mismatch.
  assign w_mismatch    = (i_dut_out !== TRUTH[r_dut_in]);
  assign w_last_vec    = (r_dut_in == '1);
  assign w_vec_state   = (SETTLE == 0) ? CHECK : gate_chk_pkg::SETTLE;
  assign w_timer_load  = w_start_ok || (r_state == CHECK);
  assign w_timer_count = (r_state == gate_chk_pkg::SETTLE);

  gate_chk_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_timer_load),
    .i_count    (w_timer_count),
    .o_expire_c (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state            <= IDLE;
      r_dut_in           <= '0;
      r_err_count        <= '0;
      r_first_fail_vec   <= '0;
      r_first_fail_valid <= 1'b0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_state            <= w_vec_state;
            r_dut_in           <= '0;
            r_err_count        <= '0;
            r_first_fail_vec   <= '0;
            r_first_fail_valid <= 1'b0;
            r_busy             <= 1'b1;
            r_done             <= 1'b0;
          end
        end
        gate_chk_pkg::SETTLE: begin
          if (w_expire) begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_mismatch) begin
            r_err_count <= r_err_count + ERR_W'(1);
            if (!r_first_fail_valid) begin
              r_first_fail_vec   <= r_dut_in;
              r_first_fail_valid <= 1'b1;
            end
          end
`ifdef GATE_VEC_CHECKER_STOP_ON_FAIL_EN
          if (w_mismatch || w_last_vec) begin
`else
          if (w_last_vec) begin
`endif
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state  <= w_vec_state;
            r_dut_in <= r_dut_in + VEC_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_dut_in           = r_dut_in;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_err_count        = r_err_count;
  assign o_first_fail_vec   = r_first_fail_vec;
  assign o_first_fail_valid = r_first_fail_valid;
  // Derived from registered state only, so it cannot glitch on inputs.
  assign o_pass             = r_done && (r_err_count == '0);

endmodule : gate_vec_checker
